// File: rtl/vga_sync_decoder.sv
// VGA stream receiver: registers a pixel-clock VGA stream, recovers pixel coordinates,
// measures line/frame timing and declares lock once the stream matches the expected mode.
module vga_sync_decoder #(
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned H_TOTAL         = 800,
    parameter int unsigned V_TOTAL         = 525,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned LOCK_FRAMES     = 2,
    parameter int unsigned CNT_W           = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vga_hs,
    input  logic             vga_vs,
    input  logic             vga_blank_n,
    input  logic [7:0]       vga_r,
    input  logic [7:0]       vga_g,
    input  logic [7:0]       vga_b,
    output logic             pix_valid,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic [7:0]       pix_r,
    output logic [7:0]       pix_g,
    output logic [7:0]       pix_b,
    output logic             frame_start,
    output logic             locked,
    output logic [CNT_W-1:0] h_total_meas,
    output logic [CNT_W-1:0] v_total_meas,
    output logic [15:0]      frame_count,
    output logic [7:0]       err_count
);

    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] HActive = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VActive = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HTotal  = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] VTotal  = CNT_W'(V_TOTAL);
    localparam logic [3:0]       LockFrames = 4'(LOCK_FRAMES);
    localparam logic             SyncInv = SYNC_ACTIVE_LOW;

    typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

    // Stage 1: syncs are stored as "asserted" flags so reset (0) means deasserted.
    logic       s1_hs_q, s1_vs_q, s1_blank_q;
    logic       hs_prev_q, vs_prev_q, blank_prev_q;
    logic [7:0] s1_r_q, s1_g_q, s1_b_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_hs_q      <= 1'b0;
            s1_vs_q      <= 1'b0;
            s1_blank_q   <= 1'b0;
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            blank_prev_q <= 1'b0;
            s1_r_q       <= 8'd0;
            s1_g_q       <= 8'd0;
            s1_b_q       <= 8'd0;
        end else begin
            s1_hs_q      <= vga_hs ^ SyncInv;
            s1_vs_q      <= vga_vs ^ SyncInv;
            s1_blank_q   <= vga_blank_n;
            hs_prev_q    <= s1_hs_q;
            vs_prev_q    <= s1_vs_q;
            blank_prev_q <= s1_blank_q;
            s1_r_q       <= vga_r;
            s1_g_q       <= vga_g;
            s1_b_q       <= vga_b;
        end
    end

    logic hs_edge, vs_edge, act_rise, act_fall;

    assign hs_edge  = s1_hs_q & ~hs_prev_q;
    assign vs_edge  = s1_vs_q & ~vs_prev_q;
    assign act_rise = s1_blank_q & ~blank_prev_q;
    assign act_fall = ~s1_blank_q & blank_prev_q;

    logic [CNT_W-1:0] h_cnt_q, v_lines_q, x_cnt_q, y_cnt_q, run_width_q;
    logic             run_seen_q, line_ok_q;
    state_e           state_q, state_d;
    logic [3:0]       match_q, match_d;
    logic             err_inc;

    logic [CNT_W-1:0] width_now, active_lines;
    logic             seen_now, timeout, line_check, line_fail, frame_pass;

    // A run ending on the same cycle as the HS edge still belongs to the line being closed.
    assign width_now    = act_fall ? x_cnt_q : run_width_q;
    assign seen_now     = run_seen_q | act_fall;
    assign active_lines = y_cnt_q + {{(CNT_W-1){1'b0}}, act_fall};
    assign timeout      = (h_cnt_q == CntMax) & ~hs_edge;
    assign line_check   = hs_edge & ~vs_edge & (v_lines_q != '0);
    // Lines with no active run (vertical blanking) are checked on length only.
    assign line_fail    = line_check &
                          ((h_cnt_q != HTotal) | (seen_now & (width_now != HActive)));
    assign frame_pass   = (v_lines_q == VTotal) & (active_lines == VActive) & line_ok_q;

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        err_inc = 1'b0;
        if (timeout) begin
            if (state_q != StSearch) begin
                err_inc = 1'b1;
            end
            state_d = StSearch;
            match_d = 4'd0;
        end else begin
            unique case (state_q)
                StSearch: begin
                    if (vs_edge) begin
                        state_d = StAcquire;
                        match_d = 4'd0;
                    end
                end
                StAcquire: begin
                    if (vs_edge) begin
                        if (!frame_pass) begin
                            match_d = 4'd0;
                        end else if (match_q + 4'd1 >= LockFrames) begin
                            state_d = StLocked;
                            match_d = 4'd0;
                        end else begin
                            match_d = match_q + 4'd1;
                        end
                    end
                end
                StLocked: begin
                    if (line_fail || (vs_edge && !frame_pass)) begin
                        state_d = StSearch;
                        err_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = StSearch;
                    match_d = 4'd0;
                end
            endcase
        end
    end

    assign locked = (state_q == StLocked);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StSearch;
            match_q      <= 4'd0;
            h_cnt_q      <= '0;
            v_lines_q    <= '0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            run_width_q  <= '0;
            run_seen_q   <= 1'b0;
            line_ok_q    <= 1'b0;
            h_total_meas <= '0;
            v_total_meas <= '0;
            frame_count  <= 16'd0;
            err_count    <= 8'd0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;

            if (hs_edge) begin
                h_cnt_q      <= CntOne;
                h_total_meas <= h_cnt_q;
            end else if (h_cnt_q != CntMax) begin
                h_cnt_q <= h_cnt_q + CntOne;
            end

            // An HS edge coincident with VS opens the new frame.
            if (vs_edge) begin
                v_lines_q    <= {{(CNT_W-1){1'b0}}, hs_edge};
                v_total_meas <= v_lines_q;
            end else if (hs_edge && v_lines_q != CntMax) begin
                v_lines_q <= v_lines_q + CntOne;
            end

            if (act_rise) begin
                x_cnt_q <= CntOne;
            end else if (s1_blank_q && x_cnt_q != CntMax) begin
                x_cnt_q <= x_cnt_q + CntOne;
            end

            if (act_fall) begin
                run_width_q <= x_cnt_q;
            end

            if (hs_edge) begin
                run_seen_q <= 1'b0;
            end else if (act_fall) begin
                run_seen_q <= 1'b1;
            end

            if (vs_edge) begin
                y_cnt_q <= '0;
            end else if (act_fall) begin
                y_cnt_q <= y_cnt_q + CntOne;
            end

            if (vs_edge) begin
                line_ok_q <= 1'b1;
            end else if (line_fail) begin
                line_ok_q <= 1'b0;
            end

            if (vs_edge) begin
                frame_count <= frame_count + 16'd1;
            end

            if (err_inc && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    // Stage 2: output register, two clocks behind the input pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_r       <= 8'd0;
            pix_g       <= 8'd0;
            pix_b       <= 8'd0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= s1_blank_q;
            pix_r       <= s1_r_q;
            pix_g       <= s1_g_q;
            pix_b       <= s1_b_q;
            frame_start <= vs_edge;
            if (s1_blank_q) begin
                pix_x <= act_rise ? '0 : x_cnt_q;
                pix_y <= y_cnt_q;
            end
        end
    end

endmodule
